// File: rtl/fifo_nibble_packer.sv
// -----------------------------------------------------------------------------
// fifo_nibble_packer
//   Drain stage that sits on the read side of a small FIFO. While the FIFO is
//   non-empty it issues read requests and captures each WIDTH-bit entry one
//   cycle later. It packs PACK consecutive entries into one OUT_W-bit word and
//   presents that word on a valid/ready output port. A flush pulse forces out
//   a partially filled word so entries are never left stranded.
//
// Ports
//   clk_in     in   1      clock, shared with the FIFO read side
//   rst_n      in   1      asynchronous active-low reset
//   empty      in   1      FIFO empty flag
//   rd_rq      out  1      FIFO read request (combinational)
//   rdata      in   WIDTH  FIFO read data, valid the cycle after an accepted rd_rq
//   flush      in   1      one-cycle pulse: emit the partial word
//   out_data   out  OUT_W  packed word
//   out_valid  out  1      out_data valid
//   out_ready  in   1      consumer accepts the word
//   out_count  out  CW     number of valid entries in out_data (1..PACK)
//   busy       out  1      entries held, a read in flight, or a word presented
//   dbg_state  out  1      current FSM state (0 = FILL, 1 = HOLD)
//
// Output handshake: a word transfers on a rising clk_in edge where
// out_valid=1 and out_ready=1. Once out_valid is raised it stays high, and
// out_data/out_count stay unchanged, until that transfer happens; out_valid
// never depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module fifo_nibble_packer #(
   parameter int WIDTH     = 4,
   parameter int PACK      = 2,
   parameter int LSB_FIRST = 1,
   localparam int OUT_W    = WIDTH * PACK,
   localparam int CW       = $clog2(PACK + 1)
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             empty,
   output logic             rd_rq,
   input  logic [WIDTH-1:0] rdata,
   input  logic             flush,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic             busy,
   output logic             dbg_state
);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CW-1:0] PACK_C  = CW'(PACK);
   localparam logic [CW:0]   PACK_C1 = (CW + 1)'(PACK);

   state_t        state;
   logic [CW-1:0] cnt;         // entries already captured into out_data
   logic          pend;        // a read was accepted last cycle; rdata arrives now
   logic          flush_pend;  // flush seen but not yet acted on
   logic [CW-1:0] cnt_inc;
   logic [CW:0]   inflight;

   // Bit offset of slot k; LSB_FIRST=0 mirrors the slot order.
   function automatic int slot_lo(input int k);
      return (LSB_FIRST != 0) ? (k * WIDTH) : ((PACK - 1 - k) * WIDTH);
   endfunction

   assign cnt_inc  = cnt + 1'b1;
   // Count the in-flight read too, so a word never gets more than PACK reads.
   assign inflight = {1'b0, cnt} + {{CW{1'b0}}, pend};

   // A pending flush blocks new reads so the partial word is cut exactly at
   // the entries already requested.
   assign rd_rq = (state == FILL) && !empty && !flush_pend && (inflight < PACK_C1);

   assign busy      = (cnt != '0) || pend || out_valid;
   assign dbg_state = (state == HOLD);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         cnt        <= '0;
         pend       <= 1'b0;
         flush_pend <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_count  <= '0;
      end else begin
         pend <= rd_rq;
         // A new pulse always wins over a clear, so a flush is never lost.
         if (flush) begin
            flush_pend <= 1'b1;
         end
         case (state)
            FILL: begin
               if (pend) begin
                  for (int k = 0; k < PACK; k++) begin
                     if (cnt == CW'(k)) begin
                        out_data[slot_lo(k) +: WIDTH] <= rdata;
                     end
                  end
                  cnt <= cnt_inc;
                  if (cnt_inc == PACK_C) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     out_count <= PACK_C;
                     if (!flush) begin
                        flush_pend <= 1'b0;
                     end
                  end
               end else if (flush_pend) begin
                  // Nothing in flight: emit the partial word, or simply
                  // retire the flush when there is nothing to emit.
                  if (cnt != '0) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     out_count <= cnt;
                  end
                  if (!flush) begin
                     flush_pend <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= FILL;
                  out_valid <= 1'b0;
                  cnt       <= '0;
                  out_data  <= '0;
                  out_count <= '0;
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule
